// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: raw buttons in, stopwatch counter-chain controls out
interface stopwatch_ctrl_if;
   logic btn_start, btn_stop, btn_clear, btn_set;
   logic run, pause, clear, load, tick;
   logic [1:0] state;
   modport master (
      output btn_start, btn_stop, btn_clear, btn_set,
      input  run, pause, clear, load, tick, state
   );
   modport slave (
      input  btn_start, btn_stop, btn_clear, btn_set,
      output run, pause, clear, load, tick, state
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button debounce, run/pause/clear/load FSM and tick prescaler
module stopwatch_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TICK_DIV        = 10
) (
   input logic             clk,
   input logic             reset_n,
   stopwatch_ctrl_if.slave bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LOAD = 2'b11} state_t;
   state_t cur, nxt;
   logic [3:0] raw, meta, s, db, db_prev, p;
   logic [DW-1:0] cnt [4];
   logic [PW-1:0] presc;
   logic clear_q;
   // bit order: 0 start, 1 stop, 2 clear, 3 set
   assign raw = {bus.btn_set, bus.btn_clear, bus.btn_stop, bus.btn_start};
   assign p   = db & ~db_prev;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta    <= '0;
         s       <= '0;
         db      <= '0;
         db_prev <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         meta    <= raw;
         s       <= meta;
         db_prev <= db;
         for (int i = 0; i < 4; i++) begin
            if (s[i] == db[i]) cnt[i] <= '0;
            else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               db[i]  <= s[i];
               cnt[i] <= '0;
            end else cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end
   always_comb begin
      nxt = cur;
      if (p[2] || cur == LOAD) nxt = IDLE;
      else if (p[1]) nxt = cur == RUN ? PAUSE : cur;
      else if (p[0]) nxt = cur == IDLE || cur == PAUSE ? RUN : cur;
      else if (p[3]) nxt = cur == IDLE ? LOAD : cur;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur     <= IDLE;
         clear_q <= 1'b0;
         presc   <= '0;
      end else begin
         cur     <= nxt;
         clear_q <= p[2];
         if (nxt == IDLE || cur == IDLE || cur == LOAD) presc <= '0;
         else if (cur == RUN) presc <= presc == PW'(TICK_DIV - 1) ? '0 : presc + 1'b1;
      end
   end
   assign bus.run   = cur == RUN;
   assign bus.pause = cur == PAUSE;
   assign bus.load  = cur == LOAD;
   assign bus.clear = clear_q;
   assign bus.state = cur;
   assign bus.tick  = bus.run && presc == PW'(TICK_DIV - 1);
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of latency, debounce, FSM priority and tick phase
module tb_stopwatch_ctrl;
   localparam int D = 4;
   logic clk, reset_n;
   logic [3:0] btn;
   int n_chk, n_fail, ticks, bad;
   logic [6:0] outs;
   stopwatch_ctrl_if bus ();
   stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(10)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );
   assign bus.btn_start = btn[0];
   assign bus.btn_stop  = btn[1];
   assign bus.btn_clear = btn[2];
   assign bus.btn_set   = btn[3];
   assign outs = {bus.run, bus.pause, bus.clear, bus.load, bus.tick, bus.state};
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   initial begin
      n_chk = 0;
      n_fail = 0;
      reset_n = 1'b0;
      btn = '0;
      #2;
      check("reset_outs", outs, 7'h00);
      step(3);
      reset_n = 1'b1;
      btn[0] = 1'b1;
      step(D + 2);
      check("start_latency_early", bus.state, 2'b00);
      step(1);
      check("start_run", {bus.run, bus.state}, 3'b101);
      step(8);
      check("tick_not_yet", bus.tick, 1'b0);
      step(1);
      check("tick_first", bus.tick, 1'b1);
      step(1);
      check("tick_one_cycle", bus.tick, 1'b0);
      step(9);
      check("tick_second", bus.tick, 1'b1);
      btn[0] = 1'b0;
      step(1);
      btn[1] = 1'b1;
      step(D + 2);
      check("stop_latency_early", bus.state, 2'b01);
      step(1);
      check("pause_outs", {bus.run, bus.pause, bus.state}, 4'b0110);
      btn[1] = 1'b0;
      ticks = 0;
      bad = 0;
      repeat (50) begin
         step(1);
         ticks += int'(bus.tick);
         bad += int'(bus.state != 2'b10);
      end
      check("pause_tick_silent", ticks, 0);
      check("pause_hold", bad, 0);
      btn[0] = 1'b1;
      step(D + 3);
      check("resume_run", bus.state, 2'b01);
      check("resume_tick0", bus.tick, 1'b0);
      step(1);
      check("resume_tick1", bus.tick, 1'b0);
      step(1);
      check("resume_tick_phase", bus.tick, 1'b1);
      btn[0] = 1'b0;
      btn[2] = 1'b1;
      step(D + 2);
      check("clear_early", {bus.clear, bus.state}, 3'b001);
      step(1);
      check("clear_pulse", {bus.run, bus.clear, bus.state}, 4'b0100);
      step(1);
      check("clear_one_cycle", bus.clear, 1'b0);
      btn[2] = 1'b0;
      btn[3] = 1'b1;
      step(D + 2);
      check("load_early", {bus.load, bus.state}, 3'b000);
      step(1);
      check("load_high", {bus.load, bus.state}, 3'b111);
      step(1);
      check("load_one_cycle", {bus.load, bus.state}, 3'b000);
      btn[3] = 1'b0;
      step(8);
      btn[0] = 1'b1;
      btn[3] = 1'b1;
      step(D + 3);
      check("start_beats_set", {bus.load, bus.state}, 3'b001);
      step(8);
      check("presc_cleared_tick0", bus.tick, 1'b0);
      step(1);
      check("presc_cleared_tick1", bus.tick, 1'b1);
      btn = '0;
      step(8);
      btn[3] = 1'b1;
      step(D + 3);
      check("set_in_run_ignored", {bus.load, bus.state}, 3'b001);
      btn[3] = 1'b0;
      btn[1] = 1'b1;
      btn[2] = 1'b1;
      step(D + 3);
      check("clear_beats_stop", {bus.pause, bus.clear, bus.state}, 4'b0100);
      btn = '0;
      step(8);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         btn[0] = (i % 4) != 3;
         step(1);
         bad += int'(bus.state != 2'b00);
      end
      check("bounce_rejected", bad, 0);
      btn[0] = 1'b1;
      step(D + 2);
      check("bounce_then_hold_early", bus.state, 2'b00);
      step(1);
      check("bounce_then_hold_run", bus.state, 2'b01);
      btn[1] = 1'b1;
      step(2);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_outs", outs, 7'h00);
      btn[1] = 1'b0;
      step(2);
      check("reset_held_outs", outs, 7'h00);
      reset_n = 1'b1;
      step(D + 2);
      check("held_start_early", bus.state, 2'b00);
      step(1);
      check("held_start_run", {bus.run, bus.state}, 3'b101);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-to-control front end for the watch controller's stopwatch digit chain. It synchronizes and debounces four raw push-buttons, runs a four-state run/pause/clear/load FSM, and emits the level and pulse controls consumed by the Mod10Counter chain (`start_resume`, `stop`, `reset`, `set`). It also emits the prescaled count-enable `tick`. It sits directly upstream of the least-significant digit counter.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a button level change. Must be ≥1.
- `TICK_DIV`, default 10: clk cycles per `tick` while running. Must be ≥1.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_start` in 1: raw start/resume button, asynchronous, active-high.
- `btn_stop` in 1: raw stop button, asynchronous, active-high.
- `btn_clear` in 1: raw clear button, asynchronous, active-high.
- `btn_set` in 1: raw load-preset button, asynchronous, active-high.
- `run` out 1: high in RUN; drives counter `start_resume`.
- `pause` out 1: high in PAUSE; drives counter `stop`.
- `clear` out 1: one-cycle pulse on accepted clear; drives counter `reset`.
- `load` out 1: high for the single LOAD cycle; drives counter `set`.
- `tick` out 1: one-cycle count enable, RUN only.
- `state` out 2: IDLE=00, RUN=01, PAUSE=10, LOAD=11.

## Operation
- Per button, the input path is:
  - A 2-flop synchronizer producing `s`.
  - A debounced level `db`, reset to 0.
  - A stability counter sized by $clog2(DEBOUNCE_CYCLES+1).
- Debounce counter behaviour:
  - It clears in every cycle where `s == db`.
  - It increments in every cycle where `s != db`.
  - On the edge where it would reach DEBOUNCE_CYCLES, `db` takes `s` and the counter clears.
- Press pulse `p_x = db & ~db_prev` is high for exactly one cycle per accepted rising level. Releases generate nothing.
- FSM, with accepted-press priority per cycle clear > stop > start > set. Lower-priority presses in the same cycle are discarded.
  - IDLE:
    - clear → IDLE, with `clear` pulse.
    - start → RUN.
    - set → LOAD.
    - stop ignored.
  - RUN:
    - clear → IDLE, with pulse.
    - stop → PAUSE.
    - start and set ignored.
  - PAUSE:
    - clear → IDLE, with pulse.
    - start → RUN (resume).
    - stop and set ignored.
  - LOAD:
    - Unconditionally → IDLE next edge.
    - A clear press in that cycle also pulses `clear`.
    - All other presses are discarded.
- Outputs:
  - `run`, `pause` and `load` are decoded from the state register (Moore).
  - `clear` is a registered pulse, high in the cycle the state register first shows IDLE after the accepted clear.
- Prescaler, sized by $clog2(TICK_DIV):
  - In RUN it increments each edge and wraps from TICK_DIV-1 to 0.
  - In PAUSE it holds.
  - It clears to 0 on any transition into IDLE and while in IDLE or LOAD.
  - `tick = run && presc == TICK_DIV-1`.
  - With TICK_DIV=1, `tick` equals `run`.

## Timing
- `reset_n` low, asynchronous:
  - State is IDLE.
  - All outputs are 0, `state` = 00.
  - Synchronizers, `db`, `db_prev`, debounce counters and prescaler are all 0.
- Reset mid-debounce or mid-run discards all progress.
- A button held across reset release is accepted as a new press after the normal latency.
- Press latency: raw high first sampled at edge k (held stable) gives:
  - `s` high after k+1.
  - `db` high after edge k+1+DEBOUNCE_CYCLES.
  - `p_x` high in the following cycle.
  - `state`/`run`/`pause`/`load`/`clear` updated after edge k+2+DEBOUNCE_CYCLES.
- Glitch rejection:
  - A raw pulse visible in `s` for fewer than DEBOUNCE_CYCLES consecutive cycles produces no press.
  - Any bounce back to the `db` level restarts the count.
- First `tick` after IDLE→RUN occurs in the TICK_DIV-th RUN cycle. Subsequent ticks occur every TICK_DIV cycles.
- Pause/resume preserves phase: tick spacing counts RUN cycles only.
- If `tick` is high in the last RUN cycle before PAUSE, it still fires. The prescaler wraps to 0 and resumes from 0.
- LOAD lasts exactly one cycle; `load` is never high for two consecutive cycles.
- `clear` is never high for two consecutive cycles from a single press.

## Test plan
- Reset, then start (D=4, TICK_DIV=10):
  - All outputs are 0 under `reset_n`=0.
  - `btn_start` high from edge 10 gives `run`=1, `state`=01 after edge 16.
  - First `tick` comes 10 cycles later, then every 10 cycles.
- Bounce rejection: `btn_start` toggled 1-1-1-0 repeatedly for 40 cycles → no state change. Then held high → RUN after exactly D+2 edges from the stable start.
- Pause/resume phase:
  - Stop after 7 RUN cycles gives PAUSE, `run`=0, `pause`=1, and `tick` silent for 50 cycles.
  - Start again gives the next `tick` after 3 RUN cycles.
- Clear and load:
  - Clear in RUN → `clear`=1 for one cycle coincident with `state`=00 and `run`=0.
  - Set in IDLE → `load`=1 for one cycle, then IDLE.
  - Set in RUN → ignored.
- Priority: stop and clear accepted in the same cycle during RUN → IDLE with `clear` pulse, never PAUSE. Start and set together in IDLE → RUN.
- Async reset mid-operation: `reset_n` low mid-RUN and mid-debounce → outputs 0 immediately, without a clock edge. Held `btn_start` across the release → RUN after D+2 edges.
